simd_scheduler: RTL

- Per-core sequencer that drives simd_state through the instruction cycle: fetch, decode, memory request/wait, execute, update.
- Owns the program counter and the done/error status.
- Its state output feeds the decoder, fetcher, LSUs, ALUs and register files of one SIMD core.
- Consumes the decoder's registered control signals (MEM_READ, MEM_WRITE, RET) and the per-thread LSU busy flags.

---
 rtl/simd_scheduler_if.sv | 31 +++
 rtl/simd_scheduler.sv | 123 ++++++++++++
 2 files changed

// File: rtl/simd_scheduler_if.sv
// Scheduler <-> core bus: launch/fetch/decoder/LSU inputs and the sequencer's registered outputs.
interface simd_scheduler_if #(
  parameter int unsigned THREADS  = 4,
  parameter int unsigned PC_WIDTH = 8
);
  logic                start;
  logic [THREADS-1:0]  thread_mask;
  logic                instr_valid;
  logic                MEM_READ;
  logic                MEM_WRITE;
  logic                RET;
  logic [THREADS-1:0]  lsu_busy;
  logic [2:0]          simd_state;
  logic [PC_WIDTH-1:0] pc;
  logic                fetch_req;
  logic                done;
  logic                error;
  logic [15:0]         instr_count;

  // Scheduler side.
  modport master (
    input  start, thread_mask, instr_valid, MEM_READ, MEM_WRITE, RET, lsu_busy,
    output simd_state, pc, fetch_req, done, error, instr_count
  );

  // Core / environment side.
  modport slave (
    output start, thread_mask, instr_valid, MEM_READ, MEM_WRITE, RET, lsu_busy,
    input  simd_state, pc, fetch_req, done, error, instr_count
  );
endinterface

// File: rtl/simd_scheduler.sv
// Per-core instruction-cycle sequencer: owns pc, done/error status and the retired count.
module simd_scheduler #(
  parameter int unsigned THREADS  = 4,
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned MAX_WAIT = 255
) (
  input logic              clk,
  input logic              rst,
  simd_scheduler_if.master bus
);

  localparam int unsigned WaitW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StDecode  = 3'd2;
  localparam logic [2:0] StRequest = 3'd3;
  localparam logic [2:0] StWait    = 3'd4;
  localparam logic [2:0] StExecute = 3'd5;
  localparam logic [2:0] StUpdate  = 3'd6;
  localparam logic [2:0] StDone    = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [THREADS-1:0]  mask_q, mask_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                error_q, error_d;
  logic [15:0]         count_q, count_d;
  logic                fetch_req_q, done_q;

  // Next-state and datapath updates for the instruction cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    wait_d  = wait_q;
    error_d = error_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mask_d  = bus.thread_mask;
          pc_d    = '0;
          count_d = '0;
          error_d = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (bus.instr_valid) state_d = StDecode;
      end
      StDecode: state_d = StRequest;
      StRequest: begin
        if (bus.MEM_READ || bus.MEM_WRITE) begin
          wait_d  = '0;
          state_d = StWait;
        end else begin
          state_d = StExecute;
        end
      end
      StWait: begin
        // Masked-off lanes never stall the core.
        if ((bus.lsu_busy & mask_q) == '0) begin
          state_d = StExecute;
        end else if (wait_q == WaitW'(MAX_WAIT - 1)) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StExecute: state_d = StUpdate;
      StUpdate: begin
        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        if (bus.RET) begin
          state_d = StDone;
        end else if (&pc_q) begin
          // pc never wraps; running off the end is a fault.
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = StFetch;
        end
      end
      StDone: begin
        if (!bus.start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; fetch_req/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      mask_q      <= '0;
      wait_q      <= '0;
      error_q     <= 1'b0;
      count_q     <= '0;
      fetch_req_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mask_q      <= mask_d;
      wait_q      <= wait_d;
      error_q     <= error_d;
      count_q     <= count_d;
      fetch_req_q <= (state_d == StFetch);
      done_q      <= (state_d == StDone);
    end
  end

  assign bus.simd_state  = state_q;
  assign bus.pc          = pc_q;
  assign bus.fetch_req   = fetch_req_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.instr_count = count_q;

endmodule
